cond_unit: RTL and testbench
============================

Name: cond_unit

Overview:
- Condition-check stage sitting directly downstream of the instruction decoder in the single-cycle ARM-subset datapath.
- Holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against the current flags.
- Gates the decoder's PCS/RegW/MemW/SLT write requests into the final datapath enables.
- Updates the flag groups selected by FlagW when the instruction executes.

Parameters:
- CNT_W, 16, width of the executed/skipped instruction counters (optional feature only; legal range 4..32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- InstrValid  input  1  the current cycle carries a real instruction; 0 means bubble.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} produced by the ALU this cycle.
- FlagW  input  2  from decoder; [1] requests an NZ update, [0] requests a CV update.
- PCS  input  1  from decoder; PC-write request (branch or Rd==15 write).
- RegW  input  1  from decoder; register-file write request.
- MemW  input  1  from decoder; data-memory write request.
- NoWrite  input  1  from decoder; suppresses the register write (CMP with S set).
- SLTW  input  1  from decoder; SLT result-write request.
- PCSrc  output  1  gated PC-select to the datapath.
- RegWrite  output  1  gated register-file write enable.
- MemWrite  output  1  gated data-memory write enable.
- SLTWrite  output  1  gated SLT write enable.
- CondEx  output  1  the current instruction passes its condition.
- Flags  output  4  registered {N,Z,C,V}.
- ExecCount  output  CNT_W  executed-instruction counter (optional feature only).
- SkipCount  output  CNT_W  condition-failed instruction counter (optional feature only).

Behaviour:
- Flag register: 4 bits; reset value 4'b0000. Flags output is the register contents directly.
- CondEx is combinational from Cond and the registered Flags (the values before this cycle's update).
- Condition encoding, with N,Z,C,V taken from Flags:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: reserved, CondEx = 0
- CondEx is forced to 0 when InstrValid=0 or reset=0.
- Output enables, combinational and zero latency:
  - PCSrc = PCS & CondEx
  - RegWrite = RegW & CondEx & ~NoWrite
  - MemWrite = MemW & CondEx
  - SLTWrite = SLTW & CondEx
- While reset=0, all four enables are 0 regardless of inputs.
- Flag update at the rising edge when CondEx=1:
  - FlagW[1]=1: Flags[3:2] <= ALUFlags[3:2].
  - FlagW[0]=1: Flags[1:0] <= ALUFlags[1:0].
  - Groups not selected hold their value.
- A failed condition or a bubble leaves Flags unchanged.
- An instruction that both reads and sets flags uses the old flags for its own CondEx; the new flags are visible from the next cycle.
- Reset has priority over every update. If reset=0 at an edge, Flags <= 0 even when a flag write is pending.
- After reset deasserts, the first edge behaves normally.
- No FSM; one state register plus optional counters. No stall input: every valid cycle retires one instruction.

Optional Feature:
- Macro: COND_UNIT_PERF_CNT_EN.
- Defined: ExecCount and SkipCount exist, each reset to 0.
  - ExecCount increments on each edge with InstrValid=1 and CondEx=1.
  - SkipCount increments on each edge with InstrValid=1 and CondEx=0.
  - Cond=1111 counts as skipped.
  - Both counters saturate at all-ones and never wrap.
  - Reset=0 clears both, with priority over increment.
- Not defined: the ExecCount and SkipCount ports and all counter logic are absent; remaining behaviour is identical.

Test Plan:
- Reset/priority: hold reset=0 with InstrValid=1, Cond=1110, RegW=1, FlagW=11, ALUFlags=1111 -> RegWrite=0, and Flags=0000 after the edge. Release reset -> the same inputs give RegWrite=1, and Flags=1111 after the next edge.
- Condition table: set Flags=0100 (Z=1) via an AL flag-setting op, then sweep Cond 0000..1111 -> CondEx pattern 1,0,0,1,0,1,0,1,0,1,1,0,0,1,1,0.
- Split flag groups: Flags=0000, FlagW=10, ALUFlags=1111 -> Flags=1100. Then FlagW=01, ALUFlags=0000 -> Flags=1100. Then FlagW=01, ALUFlags=0011 -> Flags=1111.
- CMP gating: Flags=0100, Cond=0000, RegW=1, NoWrite=1, FlagW=11, ALUFlags=1000 -> RegWrite=0, CondEx=1, and Flags=1000 next cycle. Same instruction with Cond=0001 -> CondEx=0, and Flags stays 0100.
- Branch/memory/SLT gating: PCS=MemW=SLTW=1 with Cond=1011 and Flags N=1, V=0 -> all three enables 1. With Flags N=1, V=1 -> all three 0. InstrValid=0 -> all 0 and Flags unchanged.
- Counters (macro defined, CNT_W=4): 20 valid AL instructions -> ExecCount saturates at 15. 3 instructions with Cond=1111 -> SkipCount=3. 2 bubbles -> both counters unchanged.

Source files
------------

// File: rtl/cond_unit.sv
// Condition-check stage: holds NZCV, evaluates Cond, gates decoder write requests.
// Optional COND_UNIT_PERF_CNT_EN adds saturating executed/skipped instruction counters.
module cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InstrValid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             SLTW,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             SLTWrite,
    output logic             CondEx,
    output logic [3:0]       Flags
`ifdef COND_UNIT_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
`endif
);

    logic n, z, c, v;
    logic cond_pass;

    assign {n, z, c, v} = Flags;

    always_comb begin
        cond_pass = 1'b0;
        case (Cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = ~c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = c & ~z;
            4'b1001: cond_pass = ~c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Reset folds into CondEx so every enable and the flag update are quiet during reset.
    assign CondEx   = reset & InstrValid & cond_pass;
    assign PCSrc    = PCS & CondEx;
    assign RegWrite = RegW & CondEx & ~NoWrite;
    assign MemWrite = MemW & CondEx;
    assign SLTWrite = SLTW & CondEx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            Flags <= 4'b0000;
        end else if (CondEx) begin
            if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end

`ifdef COND_UNIT_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ExecCount <= '0;
            SkipCount <= '0;
        end else if (InstrValid) begin
            if (CondEx) begin
                if (ExecCount != CNT_MAX) ExecCount <= ExecCount + 1'b1;
            end else begin
                if (SkipCount != CNT_MAX) SkipCount <= SkipCount + 1'b1;
            end
        end
    end
`else
    logic [31:0] unused_cnt_w;
    assign unused_cnt_w = 32'(CNT_W);
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Randomized + directed self-checking bench for cond_unit against a flag/counter model.
module tb_cond_unit;

    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset, InstrValid, PCS, RegW, MemW, NoWrite, SLTW;
    logic [3:0] Cond, ALUFlags;
    logic [1:0] FlagW;
    logic PCSrc, RegWrite, MemWrite, SLTWrite, CondEx;
    logic [3:0] Flags;
`ifdef COND_UNIT_PERF_CNT_EN
    logic [CW-1:0] ExecCount, SkipCount;
`endif

    cond_unit #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .InstrValid(InstrValid), .Cond(Cond),
        .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .NoWrite(NoWrite), .SLTW(SLTW), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .SLTWrite(SLTWrite), .CondEx(CondEx), .Flags(Flags)
`ifdef COND_UNIT_PERF_CNT_EN
        , .ExecCount(ExecCount), .SkipCount(SkipCount)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] flags_m;
    int exec_m, skip_m;

    // Conditions come in pairs: odd code is the inverse of the even one (AL pairs with reserved).
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit fn, fz, fc, fv, base;
        fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
        case (c[3:1])
            3'd0: base = fz;
            3'd1: base = fc;
            3'd2: base = fn;
            3'd3: base = fv;
            3'd4: base = fc && !fz;
            3'd5: base = (fn == fv);
            3'd6: base = !fz && (fn == fv);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic cex_m();
        return reset && InstrValid && cond_ok(Cond, flags_m);
    endfunction

    task automatic drive(input logic vld, input logic [3:0] c, input logic [1:0] fw,
                         input logic [3:0] af, input logic pcs, input logic regw,
                         input logic memw, input logic nowr, input logic sltw);
        InstrValid = vld; Cond = c; FlagW = fw; ALUFlags = af;
        PCS = pcs; RegW = regw; MemW = memw; NoWrite = nowr; SLTW = sltw;
        #1;
    endtask

    task automatic tick();
        bit ce;
        ce = cex_m();
        @(posedge clk);
        if (!reset) begin
            flags_m = 4'b0000; exec_m = 0; skip_m = 0;
        end else begin
            if (ce && FlagW[1]) flags_m[3:2] = ALUFlags[3:2];
            if (ce && FlagW[0]) flags_m[1:0] = ALUFlags[1:0];
            if (InstrValid && ce && exec_m < MAXC) exec_m++;
            if (InstrValid && !ce && skip_m < MAXC) skip_m++;
        end
        @(negedge clk);
    endtask

    task automatic set_flags(input logic [3:0] f);
        drive(1, 4'b1110, 2'b11, f, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1, 4'b1110, 2'b11, 4'b1111, 0, 1, 0, 0, 0);
        n_cmp++; if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL rst_regwrite got %b want 0", RegWrite); end
        tick();
        n_cmp++; if (Flags !== 4'b0000) begin n_bad++; $display("FAIL rst_flags got %b want 0000", Flags); end
`ifdef COND_UNIT_PERF_CNT_EN
        n_cmp++; if (ExecCount !== 0 || SkipCount !== 0) begin n_bad++; $display("FAIL rst_cnt got %0d/%0d want 0/0", ExecCount, SkipCount); end
`endif
        reset = 1'b1;
        #1;
        n_cmp++; if (RegWrite !== 1'b1) begin n_bad++; $display("FAIL rel_regwrite got %b want 1", RegWrite); end
        tick();
        n_cmp++; if (Flags !== 4'b1111) begin n_bad++; $display("FAIL rel_flags got %b want 1111", Flags); end
    endtask

    task automatic test_cond_table();
        logic [15:0] pat;
        pat = 16'b0110_0110_1010_1001;
        set_flags(4'b0100);
        for (int c = 0; c < 16; c++) begin
            drive(1, 4'(c), 2'b00, 4'b0000, 0, 0, 0, 0, 0);
            n_cmp++;
            if (CondEx !== pat[c]) begin n_bad++; $display("FAIL cond_table[%0d] got %b want %b", c, CondEx, pat[c]); end
        end
        tick();
    endtask

    task automatic test_split_flags();
        set_flags(4'b0000);
        drive(1, 4'b1110, 2'b10, 4'b1111, 0, 0, 0, 0, 0); tick();
        n_cmp++; if (Flags !== 4'b1100) begin n_bad++; $display("FAIL split_nz got %b want 1100", Flags); end
        drive(1, 4'b1110, 2'b01, 4'b0000, 0, 0, 0, 0, 0); tick();
        n_cmp++; if (Flags !== 4'b1100) begin n_bad++; $display("FAIL split_cv0 got %b want 1100", Flags); end
        drive(1, 4'b1110, 2'b01, 4'b0011, 0, 0, 0, 0, 0); tick();
        n_cmp++; if (Flags !== 4'b1111) begin n_bad++; $display("FAIL split_cv1 got %b want 1111", Flags); end
    endtask

    task automatic test_cmp();
        set_flags(4'b0100);
        drive(1, 4'b0000, 2'b11, 4'b1000, 0, 1, 0, 1, 0);
        n_cmp++; if ({RegWrite, CondEx} !== 2'b01) begin n_bad++; $display("FAIL cmp_eq got rw/ce %b%b want 01", RegWrite, CondEx); end
        tick();
        n_cmp++; if (Flags !== 4'b1000) begin n_bad++; $display("FAIL cmp_eq_flags got %b want 1000", Flags); end
        set_flags(4'b0100);
        drive(1, 4'b0001, 2'b11, 4'b1000, 0, 1, 0, 1, 0);
        n_cmp++; if (CondEx !== 1'b0) begin n_bad++; $display("FAIL cmp_ne got ce %b want 0", CondEx); end
        tick();
        n_cmp++; if (Flags !== 4'b0100) begin n_bad++; $display("FAIL cmp_ne_flags got %b want 0100", Flags); end
    endtask

    task automatic test_gating();
        set_flags(4'b1000);
        drive(1, 4'b1011, 2'b00, 4'b0000, 1, 0, 1, 0, 1);
        n_cmp++; if ({PCSrc, MemWrite, SLTWrite} !== 3'b111) begin n_bad++; $display("FAIL gate_lt_pass got %b want 111", {PCSrc, MemWrite, SLTWrite}); end
        set_flags(4'b1001);
        drive(1, 4'b1011, 2'b00, 4'b0000, 1, 0, 1, 0, 1);
        n_cmp++; if ({PCSrc, MemWrite, SLTWrite} !== 3'b000) begin n_bad++; $display("FAIL gate_lt_fail got %b want 000", {PCSrc, MemWrite, SLTWrite}); end
        drive(0, 4'b1110, 2'b11, 4'b0000, 1, 1, 1, 0, 1);
        n_cmp++; if ({PCSrc, RegWrite, MemWrite, SLTWrite, CondEx} !== 5'b0) begin n_bad++; $display("FAIL gate_bubble got %b want 00000", {PCSrc, RegWrite, MemWrite, SLTWrite, CondEx}); end
        tick();
        n_cmp++; if (Flags !== 4'b1001) begin n_bad++; $display("FAIL gate_bubble_flags got %b want 1001", Flags); end
    endtask

    task automatic test_random();
        logic ce;
        logic [4:0] exp_en;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 19) != 0);
            drive(($urandom_range(0, 4) != 0), 4'($urandom), 2'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            ce = cex_m();
            exp_en = {ce, PCS && ce, RegW && ce && !NoWrite, MemW && ce, SLTW && ce};
            n_cmp++;
            if ({CondEx, PCSrc, RegWrite, MemWrite, SLTWrite} !== exp_en) begin
                n_bad++; $display("FAIL rand_en[%0d] got %b want %b", i, {CondEx, PCSrc, RegWrite, MemWrite, SLTWrite}, exp_en);
            end
            tick();
            n_cmp++;
            if (Flags !== flags_m) begin n_bad++; $display("FAIL rand_flags[%0d] got %b want %b", i, Flags, flags_m); end
`ifdef COND_UNIT_PERF_CNT_EN
            n_cmp++;
            if (ExecCount !== CW'(exec_m) || SkipCount !== CW'(skip_m)) begin
                n_bad++; $display("FAIL rand_cnt[%0d] got %0d/%0d want %0d/%0d", i, ExecCount, SkipCount, exec_m, skip_m);
            end
`endif
        end
        reset = 1'b1;
    endtask

`ifdef COND_UNIT_PERF_CNT_EN
    task automatic test_counters();
        reset = 1'b0;
        drive(0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
            tick();
            n_cmp++;
            if (ExecCount !== CW'(exec_m)) begin n_bad++; $display("FAIL cnt_exec[%0d] got %0d want %0d", i, ExecCount, exec_m); end
        end
        n_cmp++; if (ExecCount !== 4'd15) begin n_bad++; $display("FAIL cnt_exec_sat got %0d want 15", ExecCount); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'b1111, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
            tick();
        end
        n_cmp++; if (SkipCount !== 4'd3) begin n_bad++; $display("FAIL cnt_skip got %0d want 3", SkipCount); end
        for (int i = 0; i < 2; i++) begin
            drive(0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
            tick();
        end
        n_cmp++;
        if (ExecCount !== 4'd15 || SkipCount !== 4'd3) begin
            n_bad++; $display("FAIL cnt_bubble got %0d/%0d want 15/3", ExecCount, SkipCount);
        end
    endtask
`endif

    initial begin
        flags_m = 4'b0000; exec_m = 0; skip_m = 0;
        reset = 1'b0;
        drive(0, 4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_cond_table();
        test_split_flags();
        test_cmp();
        test_gating();
        test_random();
`ifdef COND_UNIT_PERF_CNT_EN
        test_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
